text_console_ctrl: RTL
======================

Name: text_console_ctrl

Overview:
- Sequences writes into the 32x16 character text buffer that the tile layer reads during active display.
- Accepts a byte stream over a valid/ready handshake and maintains a cursor.
- Interprets a small set of control codes: newline, carriage return, backspace and clear screen.
- Shares the single text-buffer write port with display fetch. Writes are issued only in cycles the display flags as blank, so the tile layer always has priority.

Parameters:
- COLS, 32: characters per row; power of two; equals 2**COL_W.
- ROWS, 16: character rows; power of two; equals 2**ROW_W.
- COL_W, 5: cursor column width.
- ROW_W, 4: cursor row width.
- FILL_CHAR, 8'h20: byte written when clearing cells.

Ports:
- i_pix_clk  in  1  pixel clock; sole clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_char_valid  in  1  input byte valid.
- i_char  in  8  input byte.
- o_char_ready  out  1  block can accept a byte this cycle.
- i_blank  in  1  1 = display not reading text buffer; write port may be used this cycle.
- o_wr_en  out  1  text buffer write strobe.
- o_wr_addr  out  ROW_W+COL_W  write address, {row, col}.
- o_wr_data  out  8  write data.
- o_cursor_col  out  COL_W  current cursor column.
- o_cursor_row  out  ROW_W  current cursor row.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; cursor (0,0); o_wr_addr 0; o_wr_data 0; o_wr_en 0; o_busy 0; o_char_ready 1.
- States: IDLE, WRITE_CHAR, CLEAR_ROW, CLEAR_ALL.
- o_char_ready = (state == IDLE). A byte is accepted on a rising edge where i_char_valid && o_char_ready.
- Decode on acceptance, with the next state taking effect at the following edge:
  - 0x20..0x7E: o_wr_addr <= {row,col}, o_wr_data <= i_char, go to WRITE_CHAR with advance flag set.
  - 0x0D (CR): col <= 0, stay IDLE.
  - 0x0A (LF): perform newline (below).
  - 0x08 (BS): if col > 0, col <= col-1, o_wr_addr <= {row,col-1}, o_wr_data <= FILL_CHAR, go to WRITE_CHAR with advance flag clear. If col == 0, no-op.
  - 0x0C (FF): cursor <= (0,0), clear counter <= 0, go to CLEAR_ALL.
  - All other bytes: consumed and ignored; stay IDLE.
- Write strobe: o_wr_en = i_blank && state in {WRITE_CHAR, CLEAR_ROW, CLEAR_ALL}. It is combinational from the registered state and i_blank. o_wr_addr and o_wr_data are registered and held stable while waiting for blank.
- Writes are never issued when i_blank = 0. Any state may wait an arbitrary number of cycles for blank.
- WRITE_CHAR, on the edge where o_wr_en = 1:
  - If advance flag is clear, or col < COLS-1: col increments if advanced; go to IDLE.
  - If advance flag is set and col == COLS-1: col <= 0 and perform newline.
- Newline:
  - row <= (row == ROWS-1) ? 0 : row+1 (wrap, no scroll).
  - Then CLEAR_ROW of the new row: o_wr_addr <= {new_row, 0}, o_wr_data <= FILL_CHAR.
- CLEAR_ROW: each o_wr_en cycle writes the current address, then increments the column field. After the write to column COLS-1, go to IDLE. The cursor column is unchanged by LF; it is 0 after a wrap.
- CLEAR_ALL: same as CLEAR_ROW but walks the full address 0..ROWS*COLS-1, then goes to IDLE.
- Latency with i_blank held 1: printable byte accepted at edge T → WRITE_CHAR at T+1 with o_wr_en high → cursor updated and ready high after edge T+2.
- Full clear costs ROWS*COLS blank cycles; row clear costs COLS.
- i_blank toggling mid-clear: counter advances only on strobed cycles. No address is skipped or repeated.
- Bytes presented while busy are not accepted: ready stays low and the source holds the byte.
- Reset mid-operation: immediate return to reset state. A partially cleared buffer is acceptable; no write strobe during or after reset until a new byte is accepted.
- Cursor outputs are registered; they reflect post-operation values once IDLE is re-entered.

Test Plan:
1. Reset, i_blank=1, send 'A' (0x41) → exactly one o_wr_en pulse with addr 0x000, data 0x41. Cursor becomes (row 0, col 1); ready returns high 2 cycles after acceptance.
2. i_blank=0 for 20 cycles after sending 'B' → no o_wr_en, o_busy=1, ready=0. Raise i_blank → single write addr 0x001, data 0x42.
3. Place cursor at col 31 row 15, send 'Z' → write addr 0x1FF, data 0x5A. Then 32 writes of 0x20 to addrs 0x000..0x01F; cursor (0,0).
4. Send LF at (row 2, col 7) with i_blank pattern 1,0,1,0... → 32 writes of 0x20 to addrs 0x060..0x07F in order, no gaps or repeats. Cursor (3,7).
5. BS at col 0 → no write, cursor unchanged. BS at (1,4) → write 0x20 to 0x023, cursor (1,3). CR → cursor (1,0).
6. FF with i_blank=1 → 512 consecutive writes of 0x20 to 0x000..0x1FF, o_busy high throughout. Assert i_reset_n=0 at write 100 in a second run → o_wr_en drops immediately, cursor (0,0), state IDLE.

Source files
------------

// File: rtl/text_console_ctrl.sv
// Purpose: turns a byte stream into text-buffer writes, tracking a cursor and handling CR/LF/BS/FF.
// Latency: printable byte accepted at edge T is written on the first blank cycle after T; ready returns the edge after that write.
// Backpressure: o_char_ready low whenever a write or clear is pending; writes stall (address/data held) while i_blank is low.
module text_console_ctrl #(
    parameter int          COLS      = 32,
    parameter int          ROWS      = 16,
    parameter int          COL_W     = 5,
    parameter int          ROW_W     = 4,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic                   i_pix_clk,
    input  logic                   i_reset_n,
    input  logic                   i_char_valid,
    input  logic [7:0]             i_char,
    output logic                   o_char_ready,
    input  logic                   i_blank,
    output logic                   o_wr_en,
    output logic [ROW_W+COL_W-1:0] o_wr_addr,
    output logic [7:0]             o_wr_data,
    output logic [COL_W-1:0]       o_cursor_col,
    output logic [ROW_W-1:0]       o_cursor_row,
    output logic                   o_busy
);

    localparam int AW = ROW_W + COL_W;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WRITE_CHAR = 2'd1;
    localparam logic [1:0] S_CLEAR_ROW  = 2'd2;
    localparam logic [1:0] S_CLEAR_ALL  = 2'd3;

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    logic [1:0]       r_state;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [AW-1:0]    r_wr_addr;
    logic [7:0]       r_wr_data;
    logic             r_adv;

    logic             w_accept;
    logic             w_strobe;
    logic             w_printable;
    logic [ROW_W-1:0] w_row_next;
    logic [COL_W-1:0] w_col_dec;
    logic [COL_W-1:0] w_addr_col;

    assign o_char_ready = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    // Display fetch owns the port outside blank, so the strobe is gated here rather than in the FSM.
    assign w_strobe     = i_blank && (r_state != S_IDLE);
    assign o_wr_en      = w_strobe;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_cursor_col = r_col;
    assign o_cursor_row = r_row;

    assign w_accept    = i_char_valid && (r_state == S_IDLE);
    assign w_printable = (i_char >= 8'h20) && (i_char <= 8'h7E);
    // Rows wrap rather than scroll; the new row is wiped instead.
    assign w_row_next  = (r_row == ROW_MAX) ? '0 : r_row + ROW_W'(1);
    assign w_col_dec   = r_col - COL_W'(1);
    assign w_addr_col  = r_wr_addr[COL_W-1:0];

    // Byte decode, write sequencing and cursor update.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= S_IDLE;
            r_col     <= '0;
            r_row     <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_adv     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_printable) begin
                            r_wr_addr <= {r_row, r_col};
                            r_wr_data <= i_char;
                            r_adv     <= 1'b1;
                            r_state   <= S_WRITE_CHAR;
                        end else begin
                            case (i_char)
                                8'h0D: r_col <= '0;
                                8'h0A: begin
                                    r_row     <= w_row_next;
                                    r_wr_addr <= {w_row_next, {COL_W{1'b0}}};
                                    r_wr_data <= FILL_CHAR;
                                    r_state   <= S_CLEAR_ROW;
                                end
                                8'h08: begin
                                    // Backspace at column 0 is silently dropped.
                                    if (r_col != '0) begin
                                        r_col     <= w_col_dec;
                                        r_wr_addr <= {r_row, w_col_dec};
                                        r_wr_data <= FILL_CHAR;
                                        r_adv     <= 1'b0;
                                        r_state   <= S_WRITE_CHAR;
                                    end
                                end
                                8'h0C: begin
                                    r_row     <= '0;
                                    r_col     <= '0;
                                    r_wr_addr <= '0;
                                    r_wr_data <= FILL_CHAR;
                                    r_state   <= S_CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_WRITE_CHAR: begin
                    if (w_strobe) begin
                        if (!r_adv || (r_col != COL_MAX)) begin
                            if (r_adv) begin
                                r_col <= r_col + COL_W'(1);
                            end
                            r_state <= S_IDLE;
                        end else begin
                            // Printing in the last column wraps to a fresh, cleared line.
                            r_col     <= '0;
                            r_row     <= w_row_next;
                            r_wr_addr <= {w_row_next, {COL_W{1'b0}}};
                            r_wr_data <= FILL_CHAR;
                            r_state   <= S_CLEAR_ROW;
                        end
                    end
                end
                S_CLEAR_ROW: begin
                    if (w_strobe) begin
                        if (w_addr_col == COL_MAX) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_wr_addr <= r_wr_addr + AW'(1);
                        end
                    end
                end
                default: begin
                    // S_CLEAR_ALL: walk every cell once; address only moves on strobed cycles.
                    if (w_strobe) begin
                        if (r_wr_addr == {AW{1'b1}}) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_wr_addr <= r_wr_addr + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
